// File: rtl/buzzer_light_seq.sv
// Front-panel buzzer and stage-light sequencer: key clicks, a programmable
// end-of-program beep train with pending-finish queuing, and blinking stage LEDs.
module buzzer_light_seq #(
  parameter int unsigned N_STAGES    = 3,
  parameter int unsigned N_KEYS      = 5,
  parameter int unsigned TICK_DIV    = 25_000_000,
  parameter int unsigned KEY_TICKS   = 1,
  parameter int unsigned DONE_BEEPS  = 3,
  parameter int unsigned ON_TICKS    = 2,
  parameter int unsigned OFF_TICKS   = 2,
  parameter int unsigned BLINK_TICKS = 2,
  localparam int unsigned SW         = $clog2(N_STAGES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                power_on,
  input  logic [N_KEYS-1:0]   key_in,
  input  logic                finish,
  input  logic [1:0]          run_state,
  input  logic [N_STAGES-1:0] stage_mask,
  input  logic [SW-1:0]       cur_stage,
  output logic                buzzer,
  output logic [N_STAGES-1:0] stage_light,
  output logic                start_light,
  output logic                done_flag,
  output logic                busy
);

  localparam logic [31:0] CLICK_LEN = 32'(KEY_TICKS * TICK_DIV);
  localparam logic [31:0] ON_LEN    = 32'(ON_TICKS * TICK_DIV);
  localparam logic [31:0] OFF_LEN   = 32'(OFF_TICKS * TICK_DIV);
  localparam logic [31:0] BLINK_LEN = 32'(BLINK_TICKS * TICK_DIV);
  localparam logic [3:0]  N_BEEPS   = 4'(DONE_BEEPS);

  typedef enum logic [2:0] {S_IDLE, S_CLICK, S_D_ON, S_D_OFF, S_HOLD} state_t;

  state_t              state;
  logic [31:0]         cnt;
  logic [31:0]         blink_cnt;
  logic [3:0]          beeps;
  logic [N_KEYS-1:0]   key_q;
  logic                pend;
  logic                blink;
  logic                rise;
  logic [N_STAGES-1:0] light_n;

  assign rise = |(key_in & ~key_q);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    light_n = '0;
    if (finish) begin
      light_n = '1;
    end else begin
      case (run_state)
        2'b01: begin
          if (int'(cur_stage) < int'(N_STAGES)) begin
            for (int i = 0; i < int'(N_STAGES); i++) begin
              if (i < int'(cur_stage))       light_n[i] = 1'b0;
              else if (i == int'(cur_stage)) light_n[i] = blink;
              else                           light_n[i] = stage_mask[i];
            end
          end
        end
        2'b10: begin
          for (int i = 0; i < int'(N_STAGES); i++)
            light_n[i] = stage_mask[i] & (i >= int'(cur_stage));
        end
        default: light_n = stage_mask;
      endcase
    end
  end

  // Blink runs independently of the FSM so the active-stage LED keeps a steady rhythm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (!power_on) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_LEN - 1) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1;
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      beeps       <= '0;
      key_q       <= '0;
      pend        <= 1'b0;
      buzzer      <= 1'b0;
      stage_light <= '0;
      start_light <= 1'b0;
      done_flag   <= 1'b0;
      busy        <= 1'b0;
    end else if (!power_on) begin
      state       <= S_IDLE;
      cnt         <= '0;
      beeps       <= '0;
      key_q       <= '0;
      pend        <= 1'b0;
      buzzer      <= 1'b0;
      stage_light <= '0;
      start_light <= 1'b0;
      done_flag   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      key_q       <= key_in;
      stage_light <= light_n;
      start_light <= (run_state == 2'b01) & ~done_flag;
      cnt         <= cnt + 1;
      if (!finish) pend <= 1'b0;

      case (state)
        S_IDLE: begin
          // A queued finish from a click, or a fresh one, starts the train ahead of keys.
          if (finish && (pend || !done_flag)) begin
            state  <= S_D_ON;
            cnt    <= '0;
            beeps  <= 4'd1;
            pend   <= 1'b0;
            buzzer <= 1'b1;
            busy   <= 1'b1;
          end else if (rise) begin
            state  <= S_CLICK;
            cnt    <= '0;
            buzzer <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_CLICK: begin
          if (finish) pend <= 1'b1;
          if (cnt == CLICK_LEN - 1) begin
            state  <= S_IDLE;
            cnt    <= '0;
            buzzer <= 1'b0;
            busy   <= 1'b0;
          end
        end
        S_D_ON, S_D_OFF: begin
          if (!finish) begin
            state  <= S_IDLE;
            cnt    <= '0;
            beeps  <= '0;
            buzzer <= 1'b0;
            busy   <= 1'b0;
          end else if (state == S_D_ON) begin
            if (cnt == ON_LEN - 1) begin
              state  <= S_D_OFF;
              cnt    <= '0;
              buzzer <= 1'b0;
            end
          end else if (cnt == OFF_LEN - 1) begin
            cnt <= '0;
            if (beeps < N_BEEPS) begin
              state  <= S_D_ON;
              beeps  <= beeps + 1;
              buzzer <= 1'b1;
            end else begin
              state     <= S_HOLD;
              done_flag <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (!finish) begin
            state     <= S_IDLE;
            cnt       <= '0;
            done_flag <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          buzzer <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_light_seq.sv
// Directed bench for buzzer_light_seq (TICK_DIV=4): expectations are queued on a
// scoreboard as stimulus is driven and popped as each output sample is taken.
module tb_buzzer_light_seq;

  localparam int N_STAGES = 3;
  localparam int N_KEYS   = 5;

  localparam logic [6:0] M_BUZ   = 7'b1000000;
  localparam logic [6:0] M_LIGHT = 7'b0111000;
  localparam logic [6:0] M_START = 7'b0000100;
  localparam logic [6:0] M_DONE  = 7'b0000010;
  localparam logic [6:0] M_BUSY  = 7'b0000001;
  localparam logic [6:0] M_ALL   = 7'b1111111;

  logic                clk = 1'b0;
  logic                reset;
  logic                power_on;
  logic [N_KEYS-1:0]   key_in;
  logic                finish;
  logic [1:0]          run_state;
  logic [N_STAGES-1:0] stage_mask;
  logic [1:0]          cur_stage;
  logic                buzzer;
  logic [N_STAGES-1:0] stage_light;
  logic                start_light;
  logic                done_flag;
  logic                busy;
  logic [6:0]          outs;

  buzzer_light_seq #(.N_STAGES(N_STAGES), .N_KEYS(N_KEYS), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .power_on   (power_on),
    .key_in     (key_in),
    .finish     (finish),
    .run_state  (run_state),
    .stage_mask (stage_mask),
    .cur_stage  (cur_stage),
    .buzzer     (buzzer),
    .stage_light(stage_light),
    .start_light(start_light),
    .done_flag  (done_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign outs = {buzzer, stage_light, start_light, done_flag, busy};

  // Rising edges since reset release; drives the blink-phase model.
  int unsigned pos_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) pos_cnt <= 0;
    else       pos_cnt <= pos_cnt + 1;
  end

  typedef struct {
    string      tag;
    logic [6:0] exp;
    logic [6:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string tag, input logic [6:0] exp, input logic [6:0] mask);
    exp_t e;
    e.tag  = tag;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [6:0] obs;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=%b expected=<queued entry>", outs);
      return;
    end
    e   = sb.pop_front();
    obs = outs & e.mask;
    assert (obs === (e.exp & e.mask))
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp & e.mask);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] e;
    reset = 1'b1; power_on = 1'b1; finish = 1'b0; key_in = '0;
    run_state = 2'b00; stage_mask = 3'b111; cur_stage = 2'd0;
    cyc(2);
    push("reset_outputs", 7'b0, M_ALL);
    check();
    reset = 1'b0;
    cyc();
    push("idle_lights_mask", 7'b0111000, M_ALL);
    check();

    // Key click with a second key edge dropped mid-click.
    key_in[2] = 1'b1;
    for (int k = 1; k <= 8; k++)
      push($sformatf("click_k%0d", k), (k <= 4) ? (M_BUZ | M_BUSY) : 7'b0, M_BUZ | M_BUSY);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check();
      if (k == 2) key_in[0] = 1'b1;
    end
    key_in = '0;
    cyc(2);

    // Finish train: 3 beeps of 8 on / 8 off, then HOLD.
    run_state = 2'b01;
    finish    = 1'b1;
    for (int k = 1; k <= 48; k++)
      push($sformatf("train_k%0d", k),
           ((((k - 1) / 8) % 2) == 0) ? (M_BUZ | M_BUSY | M_START) : (M_BUSY | M_START),
           M_BUZ | M_BUSY | M_DONE | M_START);
    push("train_done", M_DONE | M_START, M_BUZ | M_BUSY | M_DONE | M_START);
    for (int k = 1; k <= 49; k++) begin
      cyc();
      check();
    end
    cyc();
    push("hold_lights_start_off", 7'b0111010, M_ALL);
    check();
    finish = 1'b0;
    cyc();
    push("hold_release", 7'b0, M_BUZ | M_BUSY | M_DONE);
    check();
    run_state = 2'b00;
    cyc();

    // Pending finish raised during a click.
    key_in[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 4)      e = M_BUZ | M_BUSY;
      else if (k == 5) e = 7'b0;
      else if (k <= 13) e = M_BUZ | M_BUSY;
      else             e = M_BUSY;
      push($sformatf("pend_k%0d", k), e, M_BUZ | M_BUSY);
    end
    for (int k = 1; k <= 14; k++) begin
      cyc();
      check();
      if (k == 2) finish = 1'b1;
    end
    finish = 1'b0;
    cyc();
    push("pend_abort", 7'b0, M_BUZ | M_BUSY);
    check();
    key_in = '0;
    cyc(2);

    // Pending finish withdrawn before the click ends.
    key_in[3] = 1'b1;
    for (int k = 1; k <= 10; k++)
      push($sformatf("pend_drop_k%0d", k), (k <= 4) ? (M_BUZ | M_BUSY) : 7'b0, M_BUZ | M_BUSY);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check();
      if (k == 2) finish = 1'b1;
      if (k == 3) finish = 1'b0;
    end
    key_in = '0;
    cyc(2);

    // Stage lights while running: light[1] follows the free-running blink.
    run_state = 2'b01;
    cur_stage = 2'd1;
    cyc();
    for (int j = 0; j < 20; j++) begin
      cyc();
      push($sformatf("blink_j%0d", j),
           {1'b0, 1'b1, 1'(((pos_cnt - 1) / 8) % 2), 1'b0, 1'b1, 2'b00}, M_ALL);
      check();
    end
    run_state = 2'b10;
    cyc();
    push("paused_lights", 7'b0110000, M_LIGHT | M_START);
    check();
    run_state = 2'b01;
    cur_stage = 2'd3;
    cyc();
    push("stage_out_of_range", 7'b0000100, M_LIGHT | M_START);
    check();
    run_state  = 2'b00;
    stage_mask = 3'b101;
    cyc();
    push("idle_mask_101", 7'b0101000, M_LIGHT | M_START);
    check();
    run_state = 2'b11;
    cyc();
    push("state11_as_idle", 7'b0101000, M_LIGHT | M_START);
    check();
    stage_mask = 3'b111;
    run_state  = 2'b00;
    cur_stage  = 2'd0;
    cyc();

    // Power drop in HOLD, then re-power with finish still high.
    finish = 1'b1;
    cyc(49);
    push("hold_reached", M_DONE, M_DONE | M_BUSY | M_BUZ);
    check();
    power_on = 1'b0;
    cyc();
    push("power_off_clear", 7'b0, M_ALL);
    check();
    power_on = 1'b1;
    cyc();
    push("repower_train", M_BUZ | M_BUSY, M_BUZ | M_BUSY | M_DONE);
    check();
    cyc(3);

    // Asynchronous reset mid-beep, then a key held high through reset release.
    reset = 1'b1;
    #1;
    push("async_reset", 7'b0, M_ALL);
    check();
    finish    = 1'b0;
    key_in[4] = 1'b1;
    cyc(2);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++)
      push($sformatf("held_key_k%0d", k), (k <= 4) ? (M_BUZ | M_BUSY) : 7'b0, M_BUZ | M_BUSY);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check();
    end
    key_in = '0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
